// File: rtl/conv_window_scheduler.sv
//==============================================================================
// Module   : conv_window_scheduler
// Function : Sliding-window convolution sequencer: pixel reads, MAC, saturated
//            result streaming over a valid/ready handshake.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module conv_window_scheduler #(
    parameter int Row_Limit   = 10,
    parameter int WindowsSize = 3,
    parameter int ACC_W       = 14,
    parameter int SHIFT       = 4
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      start,
    input  logic                                      abort,
    input  logic [5*WindowsSize*WindowsSize-1:0]      EigenMatrix,
    output logic                                      pix_rd,
    output logic [$clog2(Row_Limit*Row_Limit)-1:0]    pix_addr,
    input  logic [4:0]                                pix_data,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [4:0]                                out_data,
    output logic [$clog2(Row_Limit)-1:0]              out_row,
    output logic [$clog2(Row_Limit)-1:0]              out_col,
    output logic                                      busy,
    output logic                                      done
);

    localparam int ADDR_W = $clog2(Row_Limit * Row_Limit);
    localparam int POS_W  = $clog2(Row_Limit);
    localparam int NTAPS  = WindowsSize * WindowsSize;
    localparam int TAP_W  = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int MN_W   = (WindowsSize > 1) ? $clog2(WindowsSize) : 1;
    localparam int KERN_W = 5 * NTAPS;

    localparam logic [POS_W-1:0] c_POS_LAST = POS_W'(Row_Limit - WindowsSize);
    localparam logic [MN_W-1:0]  c_MN_LAST  = MN_W'(WindowsSize - 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_RUN   = 3'd1;
    localparam logic [2:0] c_DRAIN = 3'd2;
    localparam logic [2:0] c_OUT   = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    logic [2:0]        state_q,    state_d;
    logic [POS_W-1:0]  i_q,        i_d;
    logic [POS_W-1:0]  j_q,        j_d;
    logic [MN_W-1:0]   m_q,        m_d;
    logic [MN_W-1:0]   n_q,        n_d;
    logic [KERN_W-1:0] kernel_q,   kernel_d;
    logic [ACC_W-1:0]  acc_q,      acc_d;
    logic              rd_valid_q, rd_valid_d;
    logic [TAP_W-1:0]  rd_tap_q,   rd_tap_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;

    logic [4:0]        w_taps [NTAPS];
    logic [TAP_W-1:0]  w_tap;
    logic [ADDR_W-1:0] w_row;
    logic [ADDR_W-1:0] w_addr;
    logic [ACC_W-1:0]  w_prod;
    logic [ACC_W-1:0]  w_shifted;
    logic [4:0]        w_sat;
    logic              w_last_tap;
    logic              w_last_pos;
    logic              w_abort;

    genvar t;
    generate
        for (t = 0; t < NTAPS; t++) begin : g_taps
            assign w_taps[t] = kernel_q[5*t +: 5];
        end
    endgenerate

    assign w_tap      = TAP_W'(m_q) * TAP_W'(WindowsSize) + TAP_W'(n_q);
    assign w_row      = ADDR_W'(i_q) + ADDR_W'(m_q);
    assign w_addr     = w_row * ADDR_W'(Row_Limit) + ADDR_W'(j_q) + ADDR_W'(n_q);
    // Returned data belongs to the tap issued one cycle earlier, so the
    // kernel coefficient is selected by the delayed tap index.
    assign w_prod     = ACC_W'(pix_data) * ACC_W'(w_taps[rd_tap_q]);
    assign w_shifted  = acc_q >> SHIFT;
    assign w_sat      = (w_shifted > ACC_W'(31)) ? 5'd31 : w_shifted[4:0];
    assign w_last_tap = (m_q == c_MN_LAST) && (n_q == c_MN_LAST);
    assign w_last_pos = (i_q == c_POS_LAST) && (j_q == c_POS_LAST);
    assign w_abort    = abort && (state_q != c_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= c_IDLE;
            i_q        <= '0;
            j_q        <= '0;
            m_q        <= '0;
            n_q        <= '0;
            kernel_q   <= '0;
            acc_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_tap_q   <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            m_q        <= m_d;
            n_q        <= n_d;
            kernel_q   <= kernel_d;
            acc_q      <= acc_d;
            rd_valid_q <= rd_valid_d;
            rd_tap_q   <= rd_tap_d;
            addr_q     <= addr_d;
        end
    end

    always_comb begin : p_next_state
        state_d = state_q;
        case (state_q)
            c_IDLE:  if (start) state_d = c_RUN;
            c_RUN:   if (w_last_tap) state_d = c_DRAIN;
            c_DRAIN: state_d = c_OUT;
            c_OUT:   if (out_ready) state_d = w_last_pos ? c_DONE : c_RUN;
            c_DONE:  state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
        if (w_abort) begin
            state_d = c_IDLE;
        end
    end

    always_comb begin : p_datapath
        i_d        = i_q;
        j_d        = j_q;
        m_d        = m_q;
        n_d        = n_q;
        kernel_d   = kernel_q;
        acc_d      = acc_q;
        addr_d     = addr_q;
        rd_valid_d = (state_q == c_RUN) && !abort;
        rd_tap_d   = w_tap;

        if ((state_q == c_IDLE) && start) begin
            kernel_d = EigenMatrix;
            i_d      = '0;
            j_d      = '0;
            m_d      = '0;
            n_d      = '0;
        end

        if (state_q == c_RUN) begin
            addr_d = w_addr;
            if (n_q == c_MN_LAST) begin
                n_d = '0;
                m_d = (m_q == c_MN_LAST) ? '0 : m_q + MN_W'(1);
            end else begin
                n_d = n_q + MN_W'(1);
            end
        end

        if ((state_q == c_OUT) && out_ready && !w_last_pos) begin
            if (j_q == c_POS_LAST) begin
                j_d = '0;
                i_d = i_q + POS_W'(1);
            end else begin
                j_d = j_q + POS_W'(1);
            end
        end

        // Data still in flight when abort arrives is dropped here.
        if (rd_valid_q && ((state_q == c_RUN) || (state_q == c_DRAIN)) && !abort) begin
            acc_d = (rd_tap_q == '0) ? w_prod : acc_q + w_prod;
        end
    end

    always_comb begin : p_outputs
        pix_rd    = (state_q == c_RUN);
        pix_addr  = pix_rd ? w_addr : addr_q;
        out_valid = (state_q == c_OUT);
        out_data  = out_valid ? w_sat : 5'd0;
        out_row   = out_valid ? i_q : '0;
        out_col   = out_valid ? j_q : '0;
        busy      = (state_q != c_IDLE);
        done      = (state_q == c_DONE);
    end

endmodule

`default_nettype wire

// File: tb/tb_conv_window_scheduler.sv
//==============================================================================
// Module   : tb_conv_window_scheduler
// Function : Randomised self-checking bench against a position/tap level model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_conv_window_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        out_ready;
    logic [44:0] eigen;
    logic        pix_rd;
    logic [6:0]  pix_addr;
    logic [4:0]  pix_data = 5'd0;
    logic        out_valid;
    logic [4:0]  out_data;
    logic [3:0]  out_row;
    logic [3:0]  out_col;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    conv_window_scheduler #(
        .Row_Limit  (10),
        .WindowsSize(3),
        .ACC_W      (14),
        .SHIFT      (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .EigenMatrix(eigen),
        .pix_rd     (pix_rd),
        .pix_addr   (pix_addr),
        .pix_data   (pix_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_row    (out_row),
        .out_col    (out_col),
        .busy       (busy),
        .done       (done)
    );

    int img [100];
    int kern [9];

    // Synchronous image RAM: one cycle read latency.
    always @(posedge clk) begin
        if (pix_rd) pix_data <= 5'(img[pix_addr]);
    end

    int q_data[$];
    int q_row[$];
    int q_col[$];
    int q_addr[$];
    int done_edge, done_count, stall_cycles, stall_changes, reads_in_out;
    int busy_low_at_done, busy_after_abort, valid_after_abort;
    bit timed_out;
    int total = 0;
    int bad   = 0;

    function automatic int exp_out(int p);
        int i   = p / 8;
        int j   = p % 8;
        int acc = 0;
        for (int m = 0; m < 3; m++)
            for (int n = 0; n < 3; n++)
                acc += img[(i + m) * 10 + j + n] * kern[m * 3 + n];
        acc = acc >> 4;
        return (acc > 31) ? 31 : acc;
    endfunction

    task automatic randomize_frame();
        for (int k = 0; k < 100; k++) img[k] = int'($urandom_range(0, 31));
        for (int k = 0; k < 9; k++)   kern[k] = int'($urandom_range(0, 31));
    endtask

    // Drives one frame and records what the DUT produced; checks live in the tests.
    task automatic play_frame(input bit rand_ready, input int stall_at, input int stall_len,
                              input int abort_at, input int start_mid_edge);
        int edge_n, hold;
        bit prev_stall;
        logic [4:0] pd;
        logic [3:0] pr, pc;
        q_data.delete(); q_row.delete(); q_col.delete(); q_addr.delete();
        done_edge = -1; done_count = 0; stall_cycles = 0; stall_changes = 0;
        reads_in_out = 0; busy_low_at_done = 0; busy_after_abort = -1;
        valid_after_abort = -1; timed_out = 1'b0;
        pd = '0; pr = '0; pc = '0;
        for (int k = 0; k < 9; k++) eigen[5*k +: 5] = 5'(kern[k]);
        abort = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        edge_n = 0; hold = 0; prev_stall = 1'b0;
        forever begin
            if (done) begin
                done_count++;
                done_edge = edge_n;
                if (!busy) busy_low_at_done++;
                break;
            end
            if (pix_rd) q_addr.push_back(int'(pix_addr));
            if (out_valid) begin
                if (pix_rd) reads_in_out++;
                if (prev_stall && (out_data !== pd || out_row !== pr || out_col !== pc))
                    stall_changes++;
                pd = out_data; pr = out_row; pc = out_col;
                if (q_data.size() == stall_at && hold < stall_len) begin
                    out_ready = 1'b0;
                    hold++;
                end else if (rand_ready) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                end else begin
                    out_ready = 1'b1;
                end
                prev_stall = !out_ready;
                if (out_ready) begin
                    q_data.push_back(int'(out_data));
                    q_row.push_back(int'(out_row));
                    q_col.push_back(int'(out_col));
                end else begin
                    stall_cycles++;
                end
            end else begin
                prev_stall = 1'b0;
                out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            abort = (abort_at >= 0) && pix_rd && (q_addr.size() == abort_at + 1);
            start = (edge_n == start_mid_edge);
            @(posedge clk);
            #1 edge_n++;
            if (abort) begin
                abort = 1'b0;
                start = 1'b0;
                busy_after_abort  = int'(busy);
                valid_after_abort = int'(out_valid);
                repeat (20) begin
                    @(posedge clk);
                    #1 if (done) done_count++;
                end
                break;
            end
            if (edge_n > 3000) begin
                timed_out = 1'b1;
                break;
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1; eigen = '0;
        #23;
        total++;
        if ({pix_rd, pix_addr, out_valid, out_data, out_row, out_col, busy, done} !== 24'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h required 0",
                     {pix_rd, pix_addr, out_valid, out_data, out_row, out_col, busy, done});
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1 total++;
        if ({busy, done, out_valid, pix_rd} !== 4'd0) begin
            bad++;
            $display("FAIL idle_after_reset: busy/done/valid/rd=%b required 0000",
                     {busy, done, out_valid, pix_rd});
        end
    endtask

    task automatic test_ones();
        int errs = 0, first = -1, aerr = 0, afirst = -1, k = 0;
        for (int x = 0; x < 100; x++) img[x] = 1;
        for (int x = 0; x < 9; x++)   kern[x] = 16;
        play_frame(1'b0, -1, 0, -1, -1);
        for (int p = 0; p < q_data.size(); p++)
            if (q_data[p] !== 9 || q_row[p] !== p / 8 || q_col[p] !== p % 8) begin
                errs++; if (first < 0) first = p;
            end
        total++;
        if (errs !== 0 || q_data.size() !== 64) begin
            bad++;
            $display("FAIL ones_results: %0d wrong of %0d (first idx %0d) required 64 results of 9",
                     errs, q_data.size(), first);
        end
        total++;
        if (done_edge !== 704 || timed_out) begin
            bad++;
            $display("FAIL ones_done_edge: done after edge %0d required 704", done_edge);
        end
        for (int p = 0; p < 64; p++)
            for (int m = 0; m < 3; m++)
                for (int n = 0; n < 3; n++) begin
                    if (k >= q_addr.size() || q_addr[k] !== (p / 8 + m) * 10 + (p % 8) + n) begin
                        aerr++; if (afirst < 0) afirst = k;
                    end
                    k++;
                end
        total++;
        if (aerr !== 0 || q_addr.size() !== 576) begin
            bad++;
            $display("FAIL addr_sequence: %0d wrong of %0d issued (first at %0d) required 576 correct",
                     aerr, q_addr.size(), afirst);
        end
        total++;
        if (q_addr.size() < 1 || q_addr[q_addr.size() - 1] !== 99) begin
            bad++;
            $display("FAIL last_addr: got %0d required 99",
                     (q_addr.size() > 0) ? q_addr[q_addr.size() - 1] : -1);
        end
        total++;
        if (busy_low_at_done !== 0) begin
            bad++;
            $display("FAIL busy_with_done: busy low while done, count %0d required 0", busy_low_at_done);
        end
        @(posedge clk);
        #1 total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL after_done: done=%b busy=%b required 0 0", done, busy);
        end
    endtask

    task automatic test_saturation();
        int errs = 0;
        for (int x = 0; x < 100; x++) img[x] = 31;
        for (int x = 0; x < 9; x++)   kern[x] = 31;
        play_frame(1'b0, -1, 0, -1, -1);
        for (int p = 0; p < q_data.size(); p++) if (q_data[p] !== 31) errs++;
        total++;
        if (errs !== 0 || q_data.size() !== 64) begin
            bad++;
            $display("FAIL saturation: %0d results not 31 of %0d, required 64 results of 31",
                     errs, q_data.size());
        end
    endtask

    task automatic test_row_index();
        int errs = 0, first = -1;
        for (int x = 0; x < 100; x++) img[x] = x / 10;
        for (int x = 0; x < 9; x++)   kern[x] = (x == 4) ? 16 : 0;
        play_frame(1'b0, -1, 0, -1, -1);
        for (int p = 0; p < q_data.size(); p++)
            if (q_data[p] !== p / 8 + 1) begin errs++; if (first < 0) first = p; end
        total++;
        if (errs !== 0 || q_data.size() !== 64) begin
            bad++;
            $display("FAIL row_index: %0d wrong of %0d (first idx %0d got %0d) required row+1",
                     errs, q_data.size(), first, (first >= 0) ? q_data[first] : 0);
        end
    endtask

    task automatic test_backpressure();
        int errs = 0, first = -1;
        randomize_frame();
        play_frame(1'b0, 28, 5, -1, -1);
        for (int p = 0; p < q_data.size(); p++)
            if (q_data[p] !== exp_out(p) || q_row[p] !== p / 8 || q_col[p] !== p % 8) begin
                errs++; if (first < 0) first = p;
            end
        total++;
        if (errs !== 0 || q_data.size() !== 64) begin
            bad++;
            $display("FAIL bp_results: %0d wrong of %0d (first idx %0d) required 64 matching model",
                     errs, q_data.size(), first);
        end
        total++;
        if (stall_changes !== 0 || reads_in_out !== 0 || stall_cycles !== 5) begin
            bad++;
            $display("FAIL bp_hold: changes=%0d reads=%0d stalls=%0d required 0 0 5",
                     stall_changes, reads_in_out, stall_cycles);
        end
        total++;
        if (done_edge !== 709 || timed_out) begin
            bad++;
            $display("FAIL bp_done_edge: done after edge %0d required 709", done_edge);
        end
    endtask

    task automatic test_random_ready();
        int errs = 0, first = -1;
        randomize_frame();
        play_frame(1'b1, -1, 0, -1, -1);
        for (int p = 0; p < q_data.size(); p++)
            if (q_data[p] !== exp_out(p) || q_row[p] !== p / 8 || q_col[p] !== p % 8) begin
                errs++; if (first < 0) first = p;
            end
        total++;
        if (errs !== 0 || q_data.size() !== 64) begin
            bad++;
            $display("FAIL rr_results: %0d wrong of %0d (first idx %0d) required 64 matching model",
                     errs, q_data.size(), first);
        end
        total++;
        if (done_edge !== 704 + stall_cycles || stall_changes !== 0) begin
            bad++;
            $display("FAIL rr_timing: done after edge %0d required %0d, held-output changes %0d required 0",
                     done_edge, 704 + stall_cycles, stall_changes);
        end
    endtask

    task automatic test_abort();
        int errs = 0, first = -1;
        randomize_frame();
        play_frame(1'b0, -1, 0, 18 * 9 + 4, -1);
        total++;
        if (busy_after_abort !== 0 || valid_after_abort !== 0 || done_count !== 0) begin
            bad++;
            $display("FAIL abort_state: busy=%0d valid=%0d done_pulses=%0d required 0 0 0",
                     busy_after_abort, valid_after_abort, done_count);
        end
        for (int p = 0; p < q_data.size(); p++)
            if (q_data[p] !== exp_out(p) || q_row[p] !== p / 8 || q_col[p] !== p % 8) begin
                errs++; if (first < 0) first = p;
            end
        total++;
        if (errs !== 0 || q_data.size() !== 18) begin
            bad++;
            $display("FAIL abort_partial: %0d wrong of %0d results, required 18 matching model",
                     errs, q_data.size());
        end
        errs = 0;
        randomize_frame();
        play_frame(1'b0, -1, 0, -1, -1);
        for (int p = 0; p < q_data.size(); p++)
            if (q_data[p] !== exp_out(p) || q_row[p] !== p / 8 || q_col[p] !== p % 8) errs++;
        total++;
        if (errs !== 0 || q_data.size() !== 64 || done_edge !== 704) begin
            bad++;
            $display("FAIL abort_restart: %0d wrong of %0d, done edge %0d, required 0 of 64 at 704",
                     errs, q_data.size(), done_edge);
        end
    endtask

    task automatic test_start_abort_idle();
        @(posedge clk);
        #1 start = 1'b1; abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; abort = 1'b0;
        total++;
        if (busy !== 1'b1 || pix_rd !== 1'b1) begin
            bad++;
            $display("FAIL start_over_abort: busy=%b pix_rd=%b required 1 1", busy, pix_rd);
        end
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_run: busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid_and_start_pulse();
        int waited = 0, errs = 0;
        randomize_frame();
        for (int k = 0; k < 9; k++) eigen[5*k +: 5] = 5'(kern[k]);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; out_ready = 1'b0;
        while (!out_valid && waited < 50) begin
            @(posedge clk);
            #1 waited++;
        end
        total++;
        if (!out_valid) begin
            bad++;
            $display("FAIL reach_out: out_valid=%b after %0d cycles required 1", out_valid, waited);
        end
        #2 rst_n = 1'b0;
        #1 total++;
        if ({pix_rd, pix_addr, out_valid, out_data, out_row, out_col, busy, done} !== 24'd0) begin
            bad++;
            $display("FAIL reset_mid_out: got %h required 0",
                     {pix_rd, pix_addr, out_valid, out_data, out_row, out_col, busy, done});
        end
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        play_frame(1'b0, -1, 0, -1, 100);
        for (int p = 0; p < q_data.size(); p++)
            if (q_data[p] !== exp_out(p) || q_row[p] !== p / 8 || q_col[p] !== p % 8) errs++;
        total++;
        if (errs !== 0 || q_data.size() !== 64 || done_edge !== 704 || done_count !== 1) begin
            bad++;
            $display("FAIL start_while_busy: %0d wrong of %0d, done edge %0d pulses %0d, required 0 of 64 at 704 x1",
                     errs, q_data.size(), done_edge, done_count);
        end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_saturation();
        test_row_index();
        test_backpressure();
        test_random_ready();
        test_abort();
        test_start_abort_idle();
        test_reset_mid_and_start_pulse();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
